// File: rtl/gerenciador_ativos_seq.sv
//-----------------------------------------------------------------------------
// gerenciador_ativos_seq
//   Active-node slot manager. Keeps a table of NUM_NA node addresses with a
//   valid bitmap. An insert or remove request is accepted in idle. The table
//   is then scanned one slot per cycle from index 0. Completion is signalled
//   by a one-cycle pulse, and the bitmap is already updated when it appears.
//
// Ports
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   atualizar_in   : insert request (sampled when pronto_out=1)
//   desativar_in   : remove request (sampled when pronto_out=1, wins over insert)
//   limpar_in      : synchronous clear of all slots, aborts any request
//   endereco_in    : node address of the request
//   pronto_out     : block is idle and accepts a request
//   habilitar_out  : valid bitmap, bit i = slot i active
//   slot_out       : slot of the last successful completion
//   concluido_out  : completion pulse
//   erro_out       : failure pulse, coincident with concluido_out
//   num_ativos_out : number of active slots
//   cheio_out      : all slots active
//   vazio_out      : no slot active
//-----------------------------------------------------------------------------
`default_nettype none

module gerenciador_ativos_seq #(
  parameter int NUM_NA     = 8,
  parameter int ADR_WIDTH  = 5,
  parameter int SLOT_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  atualizar_in,
  input  logic                  desativar_in,
  input  logic                  limpar_in,
  input  logic [ADR_WIDTH-1:0]  endereco_in,
  output logic                  pronto_out,
  output logic [NUM_NA-1:0]     habilitar_out,
  output logic [SLOT_WIDTH-1:0] slot_out,
  output logic                  concluido_out,
  output logic                  erro_out,
  output logic [SLOT_WIDTH:0]   num_ativos_out,
  output logic                  cheio_out,
  output logic                  vazio_out
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PROCURANDO = 2'd1,
    ST_FIM        = 2'd2
  } estado_t;

  estado_t estado, prox_estado;

  // Request context captured at acceptance
  logic                  op_remover;
  logic [ADR_WIDTH-1:0]  endereco_reg;
  logic [SLOT_WIDTH-1:0] idx;
  logic                  livre_achado;
  logic [SLOT_WIDTH-1:0] livre_slot;

  // Address table; contents only meaningful where the valid bit is set
  logic [ADR_WIDTH-1:0]  tabela [NUM_NA];

  // Scan decode of the slot under examination
  logic                  valido_atual;
  logic                  coincide;
  logic                  ultimo;
  logic                  livre_qualquer;
  logic [SLOT_WIDTH-1:0] livre_sel;

  // Control strobes from the next-state logic
  logic                  aceitar;
  logic                  avanca;
  logic                  concluir;
  logic                  falha;
  logic                  grava;
  logic                  limpa_bit;
  logic                  atualiza_slot;
  logic [SLOT_WIDTH-1:0] slot_novo;

  assign valido_atual = habilitar_out[idx];
  // Stale addresses in invalid slots are masked out by the valid bit
  assign coincide     = valido_atual && (tabela[idx] == endereco_reg);
  assign ultimo       = (idx == SLOT_WIDTH'(NUM_NA - 1));
  // Lowest free slot: an earlier recorded one, otherwise the current slot
  assign livre_qualquer = livre_achado || !valido_atual;
  assign livre_sel      = livre_achado ? livre_slot : idx;

  //---------------------------------------------------------------------------
  // State register
  //---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= ST_IDLE;
    end else begin
      estado <= prox_estado;
    end
  end

  //---------------------------------------------------------------------------
  // Next-state and control decode
  //---------------------------------------------------------------------------
  always_comb begin
    prox_estado   = estado;
    aceitar       = 1'b0;
    avanca        = 1'b0;
    concluir      = 1'b0;
    falha         = 1'b0;
    grava         = 1'b0;
    limpa_bit     = 1'b0;
    atualiza_slot = 1'b0;
    slot_novo     = idx;

    if (limpar_in) begin
      // Clear overrides everything, including a request presented this cycle
      prox_estado = ST_IDLE;
    end else begin
      case (estado)
        ST_IDLE: begin
          if (desativar_in || atualizar_in) begin
            aceitar     = 1'b1;
            prox_estado = ST_PROCURANDO;
          end
        end

        ST_PROCURANDO: begin
          if (coincide || ultimo) begin
            prox_estado = ST_FIM;
            concluir    = 1'b1;
            if (op_remover) begin
              if (coincide) begin
                limpa_bit     = 1'b1;
                atualiza_slot = 1'b1;
                slot_novo     = idx;
              end else begin
                falha = 1'b1;
              end
            end else begin
              if (coincide) begin
                // Duplicate insert: report the slot, no write
                atualiza_slot = 1'b1;
                slot_novo     = idx;
              end else if (livre_qualquer) begin
                grava         = 1'b1;
                atualiza_slot = 1'b1;
                slot_novo     = livre_sel;
              end else begin
                falha = 1'b1;
              end
            end
          end else begin
            avanca = 1'b1;
          end
        end

        ST_FIM: begin
          prox_estado = ST_IDLE;
        end

        default: begin
          prox_estado = ST_IDLE;
        end
      endcase
    end
  end

  //---------------------------------------------------------------------------
  // Datapath registers
  //---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_remover    <= 1'b0;
      endereco_reg  <= '0;
      idx           <= '0;
      livre_achado  <= 1'b0;
      livre_slot    <= '0;
      habilitar_out <= '0;
      slot_out      <= '0;
      concluido_out <= 1'b0;
      erro_out      <= 1'b0;
    end else begin
      // Pulses are registered at the transition into ST_FIM, so they are
      // high exactly during the ST_FIM cycle
      concluido_out <= concluir;
      erro_out      <= falha;

      if (limpar_in) begin
        habilitar_out <= '0;
      end else begin
        if (grava) begin
          habilitar_out[slot_novo] <= 1'b1;
        end
        if (limpa_bit) begin
          habilitar_out[idx] <= 1'b0;
        end
      end

      if (atualiza_slot) begin
        slot_out <= slot_novo;
      end

      if (aceitar) begin
        op_remover   <= desativar_in;
        endereco_reg <= endereco_in;
        idx          <= '0;
        livre_achado <= 1'b0;
      end else if (avanca) begin
        idx <= idx + 1'b1;
        if (!livre_achado && !valido_atual) begin
          livre_achado <= 1'b1;
          livre_slot   <= idx;
        end
      end
    end
  end

  // Address storage has no reset; validity is carried by habilitar_out
  always_ff @(posedge clk) begin
    if (grava) begin
      tabela[slot_novo] <= endereco_reg;
    end
  end

  //---------------------------------------------------------------------------
  // Status derived from the bitmap
  //---------------------------------------------------------------------------
  always_comb begin
    num_ativos_out = '0;
    for (int i = 0; i < NUM_NA; i++) begin
      num_ativos_out = num_ativos_out + (SLOT_WIDTH + 1)'(habilitar_out[i]);
    end
  end

  assign cheio_out  = (num_ativos_out == (SLOT_WIDTH + 1)'(NUM_NA));
  assign vazio_out  = (num_ativos_out == '0);
  assign pronto_out = (estado == ST_IDLE);

endmodule

`default_nettype wire

// File: doc/gerenciador_ativos_seq.md
GERENCIADOR_ATIVOS_SEQ -- requirements
Module: gerenciador_ativos_seq

Interface
REQ-001 Parameter NUM_NA, default 8: number of active-node slots, >= 2.
REQ-002 Parameter ADR_WIDTH, default 5: width of a node address.
REQ-003 Parameter SLOT_WIDTH, default 3: slot index width, equal to ceil(log2(NUM_NA)).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 atualizar_in  input  1  insert request for endereco_in; sampled only when pronto_out=1.
REQ-007 desativar_in  input  1  remove request for endereco_in; sampled only when pronto_out=1.
REQ-008 limpar_in  input  1  synchronous clear of all slots, accepted in any state.
REQ-009 endereco_in  input  ADR_WIDTH  node address for the request.
REQ-010 pronto_out  output  1  high in ST_IDLE only; block accepts a request.
REQ-011 habilitar_out  output  NUM_NA  registered valid bitmap; bit i set = slot i active.
REQ-012 slot_out  output  SLOT_WIDTH  slot used by the last completed request, held until the next completion.
REQ-013 concluido_out  output  1  one-cycle pulse at request completion.
REQ-014 erro_out  output  1  one-cycle pulse, coincident with concluido_out, when the request failed.
REQ-015 num_ativos_out  output  SLOT_WIDTH+1  count of set bits in habilitar_out.
REQ-016 cheio_out / vazio_out  output  1 each  num_ativos_out==NUM_NA / num_ativos_out==0.

Function
REQ-017 The FSM SHALL have the states ST_IDLE, ST_PROCURANDO and ST_FIM.
REQ-018 ST_IDLE: on desativar_in=1 or atualizar_in=1, capture endereco_in and the operation, set scan index to 0, and go to ST_PROCURANDO.
REQ-019 If desativar_in and atualizar_in are both high in ST_IDLE, desativar SHALL win and atualizar is dropped.
REQ-020 ST_PROCURANDO SHALL examine one slot per cycle, starting at index 0, comparing the stored address only where the valid bit is set.
REQ-021 Insert: on an address match at index i, go to ST_FIM with slot=i and no write (duplicate, not an error).
REQ-022 Insert: record the lowest-index free slot seen during the scan; after index NUM_NA-1 with no match, go to ST_FIM.
REQ-023 Insert, no match, free slot f: in the ST_FIM transition write the address into f and set bit f; slot_out=f.
REQ-024 Insert, no match, no free slot: no write; erro_out=1; slot_out unchanged.
REQ-025 Remove: on a match at index i, clear bit i on the ST_FIM transition; slot_out=i.
REQ-026 Remove: if index NUM_NA-1 is passed with no match, go to ST_FIM with erro_out=1 and no change.
REQ-027 ST_FIM SHALL last exactly one cycle, with concluido_out=1, then return to ST_IDLE.
REQ-028 Latency: request accepted at edge T with its match or scan end at index k SHALL give concluido_out high in the cycle after edge T+k+1, with habilitar_out already updated in that cycle.
REQ-029 limpar_in SHALL clear habilitar_out and go to ST_IDLE on the next edge from any state, abort any request without concluido_out, and take priority over a request in the same cycle.
REQ-030 num_ativos_out, cheio_out and vazio_out SHALL be consistent with habilitar_out in every cycle.
REQ-031 Address storage SHALL not need a reset; stale addresses in invalid slots SHALL never match.

Reset
REQ-032 rst_n low SHALL immediately force ST_IDLE and set habilitar_out=0, slot_out=0, concluido_out=0, erro_out=0, num_ativos_out=0, vazio_out=1, cheio_out=0, pronto_out=1 (after release).
REQ-033 Reset during ST_PROCURANDO or ST_FIM SHALL discard the request with no completion pulse.

Verification (NUM_NA=4, ADR_WIDTH=5)
REQ-034 After reset, insert 5'h03 -> concluido 5 cycles after acceptance, slot_out=0, habilitar_out=4'b0001, num_ativos_out=1.
REQ-035 Insert 5'h03 again with slot 0 holding 5'h03 -> concluido 2 cycles after acceptance, slot_out=0, erro_out=0, habilitar_out unchanged.
REQ-036 Insert 5'h0A,5'h0B,5'h0C,5'h0D, then insert 5'h0E -> cheio_out=1 after the fourth insert; the fifth gives erro_out=1 with habilitar_out=4'hF.
REQ-037 With 4'hF and slot 2=5'h0C, remove 5'h0C, then insert 5'h1F -> bit 2 cleared (4'b1011), then slot_out=2 and 4'hF.
REQ-038 Remove 5'h11 when absent -> erro_out=1 after a full 4-slot scan; desativar_in and atualizar_in high together -> remove only.
REQ-039 limpar_in asserted mid-scan, and rst_n low mid-scan -> habilitar_out=0, vazio_out=1, no concluido_out, pronto_out=1 next cycle.
